// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, picks the next fetch address from the
// ID-resolved redirect sources, and loads the IF/ID pipeline register.
module if_stage #(
   parameter logic [31:0] TEXT_BASE = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic [1:0]  id_npc_op,
   input  logic        id_branch_taken,
   input  logic [15:0] id_imm16,
   input  logic [25:0] id_target26,
   input  logic [31:0] id_rs_val,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic [31:0] if_pc,
   output logic [31:0] id_pc,
   output logic [31:0] id_inst,
   output logic        id_valid,
   output logic [31:0] fetch_count
);

   localparam logic [1:0] NPC_SEQ    = 2'b00;
   localparam logic [1:0] NPC_BRANCH = 2'b01;
   localparam logic [1:0] NPC_JUMP   = 2'b10;
   localparam logic [1:0] NPC_JR     = 2'b11;

   logic [31:0] pc_q, pc_d;
   logic [31:0] id_pc_q, id_pc_d;
   logic [31:0] id_inst_q, id_inst_d;
   logic        id_valid_q, id_valid_d;
   logic [31:0] fetch_count_q, fetch_count_d;

   logic [31:0] pc_plus4;
   logic [31:0] id_pc_plus4;
   logic [31:0] br_offset;
   logic [31:0] redir_target;
   logic        redir;

   assign pc_plus4    = pc_q + 32'd4;
   assign id_pc_plus4 = id_pc_q + 32'd4;
   assign br_offset   = {{14{id_imm16[15]}}, id_imm16, 2'b00};

   // A bubble in ID must never redirect, and a stalled edge defers the decision.
   assign redir = id_valid_q && !stall &&
                  ((id_npc_op == NPC_JUMP) || (id_npc_op == NPC_JR) ||
                   ((id_npc_op == NPC_BRANCH) && id_branch_taken));

   always_comb begin
      redir_target = pc_plus4;
      case (id_npc_op)
         NPC_BRANCH: redir_target = id_pc_plus4 + br_offset;
         NPC_JUMP:   redir_target = {id_pc_plus4[31:28], id_target26, 2'b00};
         NPC_JR:     redir_target = {id_rs_val[31:2], 2'b00};
         NPC_SEQ:    redir_target = pc_plus4;
         default:    redir_target = pc_plus4;
      endcase
   end

   always_comb begin
      pc_d          = pc_q;
      id_pc_d       = id_pc_q;
      id_inst_d     = id_inst_q;
      id_valid_d    = id_valid_q;
      fetch_count_d = fetch_count_q;
      if (stall) begin
         pc_d = pc_q;
      end else if (redir) begin
         // Squash the wrong-path fetch; keep its PC for visibility.
         pc_d       = redir_target;
         id_pc_d    = pc_q;
         id_inst_d  = 32'd0;
         id_valid_d = 1'b0;
      end else begin
         pc_d          = pc_plus4;
         id_pc_d       = pc_q;
         id_inst_d     = imem_rdata;
         id_valid_d    = 1'b1;
         fetch_count_d = fetch_count_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q          <= TEXT_BASE;
         id_pc_q       <= 32'd0;
         id_inst_q     <= 32'd0;
         id_valid_q    <= 1'b0;
         fetch_count_q <= 32'd0;
      end else begin
         pc_q          <= pc_d;
         id_pc_q       <= id_pc_d;
         id_inst_q     <= id_inst_d;
         id_valid_q    <= id_valid_d;
         fetch_count_q <= fetch_count_d;
      end
   end

   assign imem_addr   = pc_q;
   assign if_pc       = pc_q;
   assign id_pc       = id_pc_q;
   assign id_inst     = id_inst_q;
   assign id_valid    = id_valid_q;
   assign fetch_count = fetch_count_q;

endmodule
